// File: rtl/micro_mem_responder_if.sv
// micro_mem_responder_if: core fetch/data buses and program-loader handshake.
// slave is the responder side; master is the core/loader side.
interface micro_mem_responder_if;
    logic [7:0] i_Address_Instruction_Bus;
    logic [8:0] o_Instruction;
    logic [7:0] i_Address_Data_Bus;
    logic [7:0] i_DataOut_Bus;
    logic       i_Data_We;
    logic [7:0] o_Data_bus;
    logic       i_Load_Valid;
    logic       o_Load_Ready;
    logic [8:0] i_Load_Data;
    logic       i_Load_Last;
    logic       i_Reload;
    logic       o_Core_Rst;
    logic       o_Load_Err;
    logic [8:0] o_Load_Csum;
    modport slave (
        input  i_Address_Instruction_Bus, i_Address_Data_Bus, i_DataOut_Bus, i_Data_We,
               i_Load_Valid, i_Load_Data, i_Load_Last, i_Reload,
        output o_Instruction, o_Data_bus, o_Load_Ready, o_Core_Rst, o_Load_Err, o_Load_Csum
    );
    modport master (
        output i_Address_Instruction_Bus, i_Address_Data_Bus, i_DataOut_Bus, i_Data_We,
               i_Load_Valid, i_Load_Data, i_Load_Last, i_Reload,
        input  o_Instruction, o_Data_bus, o_Load_Ready, o_Core_Rst, o_Load_Err, o_Load_Csum
    );
endinterface

// File: rtl/micro_mem_responder.sv
// micro_mem_responder: instruction/data memory for the 5A core with a LOAD/RUN program loader.
// Define MEM_LOAD_CSUM_EN to build the XOR checksum of loaded words on o_Load_Csum.
module micro_mem_responder #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic i_Clk,
    input  logic i_Rst,
    micro_mem_responder_if.slave bus
);
    typedef enum logic {LOAD, RUN} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_ptr;
    logic       r_err;
    logic [8:0] r_imem [IMEM_DEPTH];
    logic [7:0] r_dmem [DMEM_DEPTH];
    logic       w_accept, w_full, w_reload, w_imem_hit, w_dmem_hit, w_dwe;
    assign w_accept   = bus.i_Load_Valid && r_state == LOAD;
    assign w_full     = 32'(r_ptr) == IMEM_DEPTH - 1;
    assign w_reload   = bus.i_Reload && r_state == RUN;
    assign w_imem_hit = 32'(bus.i_Address_Instruction_Bus) < IMEM_DEPTH;
    assign w_dmem_hit = 32'(bus.i_Address_Data_Bus) < DMEM_DEPTH;
    assign w_dwe      = bus.i_Data_We && r_state == RUN && w_dmem_hit;
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) r_state <= LOAD;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == LOAD) ? ((w_accept && (bus.i_Load_Last || w_full)) ? RUN : LOAD)
                                   : (bus.i_Reload ? LOAD : RUN);
    end
    // The final slot ends the load even without last; ptr wraps but state has left LOAD.
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            r_ptr <= 8'd0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + 8'd1;
            if (w_full && !bus.i_Load_Last) r_err <= 1'b1;
        end else if (w_reload) begin
            r_ptr <= 8'd0;
            r_err <= 1'b0;
        end
    always_ff @(posedge i_Clk) begin
        if (w_accept) r_imem[r_ptr] <= bus.i_Load_Data;
        if (w_dwe) r_dmem[bus.i_Address_Data_Bus] <= bus.i_DataOut_Bus;
    end
    assign bus.o_Load_Ready  = r_state == LOAD;
    assign bus.o_Core_Rst    = r_state == LOAD;
    assign bus.o_Load_Err    = r_err;
    assign bus.o_Instruction = (r_state == RUN && w_imem_hit) ? r_imem[bus.i_Address_Instruction_Bus] : 9'h000;
    assign bus.o_Data_bus    = (r_state == RUN && w_dmem_hit) ? r_dmem[bus.i_Address_Data_Bus] : 8'h00;
`ifdef MEM_LOAD_CSUM_EN
    logic [8:0] r_csum;
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) r_csum <= 9'h000;
        else if (w_accept) r_csum <= r_csum ^ bus.i_Load_Data;
        else if (w_reload) r_csum <= 9'h000;
    assign bus.o_Load_Csum = r_csum;
`else
    assign bus.o_Load_Csum = 9'h000;
`endif
endmodule

// File: doc/micro_mem_responder.md
# micro_mem_responder

Memory-side responder for the 5A microcontroller. It serves the core's instruction fetch bus (8-bit address → 9-bit instruction) and data bus (8-bit address, read/write). It also owns a program-load state machine that streams words into instruction memory over a valid/ready handshake while holding the core in reset. It sits between the microcontroller top and the board-level loader, so the core always starts executing from a freshly loaded program.

## Interface
- IMEM_DEPTH, 256: instruction memory words (9-bit); must be ≤256.
- DMEM_DEPTH, 256: data memory bytes; must be ≤256.
- i_Clk  in  1  rising-edge clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Address_Instruction_Bus  in  8  fetch address from the core's PC.
- o_Instruction  out  9  instruction word for the core.
- i_Address_Data_Bus  in  8  data address from the core.
- i_DataOut_Bus  in  8  write data from the core.
- i_Data_We  in  1  data write strobe from the core.
- o_Data_bus  out  8  read data to the core.
- i_Load_Valid  in  1  loader word valid.
- o_Load_Ready  out  1  responder accepts a load word.
- i_Load_Data  in  9  instruction word to store.
- i_Load_Last  in  1  marks the final word of the program.
- i_Reload  in  1  single-cycle request to restart loading.
- o_Core_Rst  out  1  reset to the microcontroller (active-high).
- o_Load_Err  out  1  sticky flag: load overflowed IMEM_DEPTH.
- o_Load_Csum  out  9  XOR checksum of the loaded words (see Configuration).

## Operation
- FSM states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - o_Load_Ready=1, o_Core_Rst=1, o_Instruction=9'h000, o_Data_bus=8'h00.
  - Data writes are ignored.
  - Each accept (i_Load_Valid & o_Load_Ready at an edge) writes i_Load_Data to imem[ptr], then ptr←ptr+1 (8-bit ptr).
  - Accept with i_Load_Last=1 → RUN.
  - Accept at ptr=IMEM_DEPTH-1 without last → RUN and o_Load_Err←1. The word at IMEM_DEPTH-1 is still written, and ptr does not wrap into a further write.
- RUN:
  - o_Load_Ready=0, o_Core_Rst=0.
  - o_Instruction = imem[i_Address_Instruction_Bus] (combinational read).
  - o_Data_bus = dmem[i_Address_Data_Bus] (combinational read).
  - i_Data_We=1 writes i_DataOut_Bus to dmem[i_Address_Data_Bus] at the edge.
  - Addresses ≥ depth read 0. Writes to addresses ≥ depth are dropped.
  - i_Reload=1 → LOAD at the next edge: ptr←0, o_Load_Err←0, checksum←0.
  - i_Reload is ignored while in LOAD.
- Imem locations not loaded keep their previous contents.
- Memory contents are not reset. Only state, ptr, flags and outputs are reset.

## Timing
- Reset values: state=LOAD, ptr=0, o_Load_Ready=1, o_Core_Rst=1, o_Load_Err=0, o_Load_Csum=0, o_Instruction=0, o_Data_bus=0.
- Asynchronous reset mid-load aborts the load immediately. ptr returns to 0. Words already written stay in memory.
- o_Load_Ready, o_Core_Rst and o_Load_Err are registered from state and flags.
  - When the last word is accepted at edge N, o_Load_Ready and o_Core_Rst fall after edge N.
  - The core sees its first fetch of address 0 in cycle N+1.
- i_Reload accepted at edge M: o_Core_Rst and o_Load_Ready rise after edge M. The first word is accepted at edge M+1 at the earliest.
- Fetch and data read latency: 0 cycles (combinational).
- Data read-during-write to the same address returns the old byte until the edge and the new byte after it.
- i_Reload and i_Data_We in the same RUN cycle: the write completes and state goes to LOAD.
- Loader may hold i_Load_Valid high across the RUN transition. No accept occurs while o_Load_Ready=0.

## Configuration
- MEM_LOAD_CSUM_EN defined: o_Load_Csum ← o_Load_Csum ^ i_Load_Data on every accept. It is cleared on reset and on entering LOAD, and held in RUN.
- Not defined: o_Load_Csum is tied to 9'h000 and no checksum logic is built.

## Test plan
- Reset, then load 3 words 9'h101, 9'h0A2, 9'h1FF (last on the third) → 3 accepts; o_Core_Rst falls after the third edge; fetch addr 0/1/2 returns 101/0A2/1FF; o_Load_Csum=9'h05C with the macro, 0 without.
- RUN: write 8'h5A to data addr 8'h10 with i_Data_We=1 → o_Data_bus=8'h5A at addr 10 from the next cycle; same-cycle read shows the old value.
- Stream 256 words without i_Load_Last → RUN after the 256th accept, o_Load_Err=1, imem[255] holds the 256th word.
- Assert i_Reload in RUN → o_Core_Rst=1 and o_Load_Ready=1 next cycle, o_Load_Err=0; load 1 word 9'h033 with last → fetch addr 0 returns 033, addr 1 keeps its old word.
- Assert i_Rst after 2 of 4 load words → ready=1, ptr=0; restart the load and check 4 words at addrs 0-3.
- In LOAD, drive i_Data_We=1 to addr 8'h20 with 8'hFF → dmem[20] unchanged after RUN is reached; o_Instruction=0 throughout LOAD.
